// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command bus arbiter: init ownership, then refresh > write > read grants with a busy watchdog.
// Optional SDRAM_ARB_RR_EN alternates write/read grants when both request together.
module sdram_cmd_arbiter #(
   parameter logic [10:0] MAX_BUSY_CLK = 11'd1100,
   parameter logic [3:0]  NOP          = 4'b0111
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_end,
   input  logic [3:0]  init_cmd,
   input  logic [1:0]  init_ba,
   input  logic [12:0] init_addr,
   input  logic        aref_req,
   input  logic        aref_end,
   input  logic [3:0]  aref_cmd,
   input  logic [1:0]  aref_ba,
   input  logic [12:0] aref_addr,
   output logic        aref_en,
   input  logic        wr_req,
   input  logic        wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [1:0]  wr_ba,
   input  logic [12:0] wr_addr,
   input  logic        wr_sdram_en,
   input  logic [15:0] wr_data,
   output logic        wr_en,
   input  logic        rd_req,
   input  logic        rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [1:0]  rd_ba,
   input  logic [12:0] rd_addr,
   output logic        rd_en,
   output logic        sdram_cke,
   output logic        sdram_cs_n,
   output logic        sdram_ras_n,
   output logic        sdram_cas_n,
   output logic        sdram_we_n,
   output logic [1:0]  sdram_ba,
   output logic [12:0] sdram_addr,
   inout  wire  [15:0] sdram_dq,
   output logic        arb_err
);

   typedef enum logic [2:0] {
      ARB_INIT,
      ARB_ARB,
      ARB_AREF,
      ARB_WRITE,
      ARB_READ
   } arb_state_t;

   arb_state_t  state, state_nxt;
   logic [10:0] busy_cnt;
   logic        busy;
   logic        owner_end;
   logic        timeout;
   logic        rr_pick_rd;
   logic [3:0]  cmd;

   assign busy      = (state == ARB_AREF) || (state == ARB_WRITE) || (state == ARB_READ);
   assign owner_end = ((state == ARB_AREF)  && aref_end) ||
                      ((state == ARB_WRITE) && wr_end)   ||
                      ((state == ARB_READ)  && rd_end);

`ifdef SDRAM_ARB_RR_EN
   logic last_wr;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         last_wr <= 1'b0;
      else if (state == ARB_ARB && state_nxt == ARB_WRITE)
         last_wr <= 1'b1;
      else if (state == ARB_ARB && state_nxt == ARB_READ)
         last_wr <= 1'b0;
   end

   assign rr_pick_rd = last_wr;
`else
   assign rr_pick_rd = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      timeout   = 1'b0;
      case (state)
         ARB_INIT:
            if (init_end) state_nxt = ARB_ARB;
         ARB_ARB:
            if (aref_req)              state_nxt = ARB_AREF;
            else if (wr_req && rd_req) state_nxt = rr_pick_rd ? ARB_READ : ARB_WRITE;
            else if (wr_req)           state_nxt = ARB_WRITE;
            else if (rd_req)           state_nxt = ARB_READ;
         ARB_AREF, ARB_WRITE, ARB_READ:
            if (owner_end) begin
               state_nxt = ARB_ARB;
            end else if (busy_cnt == MAX_BUSY_CLK - 11'd1) begin
               state_nxt = ARB_ARB;
               timeout   = 1'b1;
            end
         default:
            state_nxt = ARB_INIT;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ARB_INIT;
         busy_cnt  <= '0;
         arb_err   <= 1'b0;
         sdram_cke <= 1'b0;
      end else begin
         state     <= state_nxt;
         busy_cnt  <= busy ? busy_cnt + 11'd1 : '0;
         arb_err   <= timeout;
         sdram_cke <= 1'b1;
      end
   end

   // cke is low only in reset and until the first clock after it, so it doubles as the pin-idle gate
   always_comb begin
      cmd        = NOP;
      sdram_ba   = '1;
      sdram_addr = '1;
      if (sdram_cke) begin
         case (state)
            ARB_INIT:  begin cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
            ARB_AREF:  begin cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
            ARB_WRITE: begin cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
            ARB_READ:  begin cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
            default:   begin cmd = NOP;      sdram_ba = '1;      sdram_addr = '1;        end
         endcase
      end
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

   assign aref_en = (state == ARB_AREF);
   assign wr_en   = (state == ARB_WRITE);
   assign rd_en   = (state == ARB_READ);

   assign sdram_dq = (state == ARB_WRITE && wr_sdram_en) ? wr_data : 'z;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: grant order checked by a monitor, pins/dq/watchdog checked inline.
module tb_sdram_cmd_arbiter;

   localparam logic [3:0]  NOP_C  = 4'b0111;
   localparam logic [2:0]  G_AREF = 3'b001;
   localparam logic [2:0]  G_WR   = 3'b010;
   localparam logic [2:0]  G_RD   = 3'b100;

   logic        sys_clk     = 1'b0;
   logic        sys_rst_n   = 1'b0;
   logic        init_end    = 1'b0;
   logic [3:0]  init_cmd    = 4'b0010;
   logic [1:0]  init_ba     = 2'b01;
   logic [12:0] init_addr   = 13'h0400;
   logic        aref_req    = 1'b0;
   logic        aref_end    = 1'b0;
   logic [3:0]  aref_cmd    = 4'b0001;
   logic [1:0]  aref_ba     = 2'b00;
   logic [12:0] aref_addr   = 13'h0011;
   logic        aref_en;
   logic        wr_req      = 1'b0;
   logic        wr_end      = 1'b0;
   logic [3:0]  wr_cmd      = 4'b0100;
   logic [1:0]  wr_ba       = 2'b10;
   logic [12:0] wr_addr     = 13'h0222;
   logic        wr_sdram_en = 1'b0;
   logic [15:0] wr_data     = 16'hA5A5;
   logic        wr_en;
   logic        rd_req      = 1'b0;
   logic        rd_end      = 1'b0;
   logic [3:0]  rd_cmd      = 4'b0101;
   logic [1:0]  rd_ba       = 2'b01;
   logic [12:0] rd_addr     = 13'h0333;
   logic        rd_en;
   logic        sdram_cke;
   logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;
   wire  [15:0] sdram_dq;
   logic        arb_err;

   int          total = 0;
   int          bad   = 0;
   logic [2:0]  exp_q[$];
   logic [2:0]  g;
   logic [2:0]  g_prev = 3'b000;
   logic [2:0]  g_or;
   int          wd_cycles;
   bit          seen;
   int          w;

   sdram_cmd_arbiter #(.MAX_BUSY_CLK(11'd1100), .NOP(4'b0111)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
      .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
      .aref_ba(aref_ba), .aref_addr(aref_addr), .aref_en(aref_en),
      .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
      .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_data(wr_data), .wr_en(wr_en),
      .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
      .rd_addr(rd_addr), .rd_en(rd_en), .sdram_cke(sdram_cke),
      .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
      .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
      .sdram_dq(sdram_dq), .arb_err(arb_err)
   );

   always #5 sys_clk = ~sys_clk;

   assign g = {rd_en, wr_en, aref_en};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_bus(input string name, input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
      chk({name, "_cmd"},  32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(c));
      chk({name, "_ba"},   32'(sdram_ba), 32'(b));
      chk({name, "_addr"}, 32'(sdram_addr), 32'(a));
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Monitor: every new grant pops the next expected owner from the scoreboard
   always @(negedge sys_clk) begin
      chk("grant_onehot", 32'($onehot0(g)), 32'd1);
      if (g != 3'b000 && g_prev == 3'b000) begin
         if (exp_q.size() == 0) chk("grant_unexpected", 32'(g), 32'd0);
         else                   chk("grant_order", 32'(g), 32'(exp_q.pop_front()));
      end
      g_prev = g;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #2;
      chk_bus("rst", NOP_C, 2'b11, 13'h1fff);
      chk("rst_cke", 32'(sdram_cke), 32'd0);
      chk("rst_grants", 32'(g), 32'd0);
      chk("rst_err", 32'(arb_err), 32'd0);
      tick();
      sys_rst_n = 1'b1;

      g_or = 3'b000;
      repeat (200) begin tick(); g_or |= g; end
      chk("init_cke", 32'(sdram_cke), 32'd1);
      chk_bus("init", 4'b0010, 2'b01, 13'h0400);
      chk("init_grants", 32'(g_or), 32'd0);
      init_end = 1'b1;
      tick();
      chk_bus("arb_idle", NOP_C, 2'b11, 13'h1fff);

      // priority: all three request at once
      aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      exp_q.push_back(G_AREF); exp_q.push_back(G_WR); exp_q.push_back(G_RD);
      tick();
      chk("aref_en", 32'(aref_en), 32'd1);
      chk_bus("aref_bus", 4'b0001, 2'b00, 13'h0011);
      aref_end = 1'b1; aref_req = 1'b0;
      tick();
      aref_end = 1'b0;
      chk("aref_end_gap", 32'(g), 32'd0);
      chk_bus("aref_end_nop", NOP_C, 2'b11, 13'h1fff);
      tick();
      chk("wr_en", 32'(wr_en), 32'd1);
      chk_bus("wr_bus", 4'b0100, 2'b10, 13'h0222);
      rd_end = 1'b1;
      tick();
      rd_end = 1'b0;
      chk("stray_rd_end", 32'(wr_en), 32'd1);
      wr_sdram_en = 1'b1; #1;
      chk("dq_drive", 32'(sdram_dq === 16'hA5A5), 32'd1);
      wr_sdram_en = 1'b0; #1;
      chk("dq_z_noen", 32'(sdram_dq === 16'hA5A5), 32'd0);
      wr_end = 1'b1; wr_req = 1'b0;
      tick();
      wr_end = 1'b0;
      chk("wr_end_gap", 32'(g), 32'd0);
      tick();
      chk("rd_en", 32'(rd_en), 32'd1);
      chk_bus("rd_bus", 4'b0101, 2'b01, 13'h0333);
      wr_sdram_en = 1'b1; #1;
      chk("dq_z_read", 32'(sdram_dq === 16'hA5A5), 32'd0);
      wr_sdram_en = 1'b0;
      rd_end = 1'b1; rd_req = 1'b0;
      tick();
      rd_end = 1'b0;

      // watchdog: write grant never ends
      wr_req = 1'b1;
      exp_q.push_back(G_WR);
      tick();
      wd_cycles = 0; seen = 1'b0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         if (arb_err) seen = 1'b1;
         else begin
            if (wr_en) wd_cycles++;
            tick();
         end
      end
      chk("wd_seen", 32'(seen), 32'd1);
      chk("wd_len", 32'(wd_cycles), 32'd1100);
      chk("wd_wr_en", 32'(wr_en), 32'd0);
      chk_bus("wd_nop", NOP_C, 2'b11, 13'h1fff);
      wr_req = 1'b0;
      tick();
      chk("wd_pulse", 32'(arb_err), 32'd0);
      chk("wd_idle", 32'(g), 32'd0);

      // reset in the middle of a read
      rd_req = 1'b1;
      exp_q.push_back(G_RD);
      tick();
      tick();
      chk("rd2_en", 32'(rd_en), 32'd1);
      #1;
      sys_rst_n = 1'b0; rd_req = 1'b0; init_end = 1'b0;
      #1;
      chk_bus("rst_mid", NOP_C, 2'b11, 13'h1fff);
      chk("rst_mid_rd_en", 32'(rd_en), 32'd0);
      chk("rst_mid_cke", 32'(sdram_cke), 32'd0);
      tick();
      tick();
      sys_rst_n = 1'b1;
      tick();
      chk("rst_rel_cke", 32'(sdram_cke), 32'd1);
      chk_bus("rst_rel_init", 4'b0010, 2'b01, 13'h0400);
      init_end = 1'b1;
      tick();
      chk_bus("rst_rel_arb", NOP_C, 2'b11, 13'h1fff);

      // write and read held together through four grants
      wr_req = 1'b1; rd_req = 1'b1;
`ifdef SDRAM_ARB_RR_EN
      exp_q.push_back(G_WR); exp_q.push_back(G_RD); exp_q.push_back(G_WR); exp_q.push_back(G_RD);
`else
      exp_q.push_back(G_WR); exp_q.push_back(G_WR); exp_q.push_back(G_WR); exp_q.push_back(G_WR);
`endif
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (g == 3'b000 && w < 10) begin tick(); w++; end
         chk("rr_grant_wait", 32'(g != 3'b000), 32'd1);
         if (wr_en)      wr_end = 1'b1;
         else if (rd_en) rd_end = 1'b1;
         if (k == 3) begin wr_req = 1'b0; rd_req = 1'b0; end
         tick();
         wr_end = 1'b0; rd_end = 1'b0;
      end
      repeat (3) tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
